// File: rtl/systolic_gemm_engine.sv
// systolic_gemm_engine: self-sequencing output-stationary systolic GEMM,
// C[ROWS][COLS] = A[ROWS][DEPTH] x B[DEPTH][COLS] with signed operands.
// A enters each row from the left skewed by the row index; B enters each
// column from the top skewed by the column index; each PE keeps its own sum.
// Build macro SYSTOLIC_SATURATE_EN: accumulators clamp to the signed output
// range instead of wrapping, and the sat_flag output reports any clamping.
module systolic_gemm_engine #(
  parameter int ROWS              = 4,
  parameter int COLS              = 4,
  parameter int DEPTH             = 4,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int OUTPUT_DATA_WIDTH = 32
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  input  logic [ROWS-1:0][DEPTH-1:0][INPUT_DATA_WIDTH-1:0]     a_mat,
  input  logic [DEPTH-1:0][COLS-1:0][INPUT_DATA_WIDTH-1:0]     b_mat,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 c_valid,
  output logic [ROWS-1:0][COLS-1:0][OUTPUT_DATA_WIDTH-1:0]     c_mat
`ifdef SYSTOLIC_SATURATE_EN
  ,
  output logic                                                 sat_flag
`endif
);

  localparam int IW    = INPUT_DATA_WIDTH;
  localparam int OW    = OUTPUT_DATA_WIDTH;
  localparam int T     = DEPTH + ROWS + COLS - 2;
  localparam int CNT_W = $clog2(T + 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;
  logic   start_acc;
  int     step_nxt;

  logic signed [IW-1:0] a_cap_p0 [ROWS][DEPTH];
  logic signed [IW-1:0] b_cap_p0 [DEPTH][COLS];
  logic [CNT_W-1:0]     t_p0;

  logic signed [IW-1:0] a_feed  [ROWS];
  logic signed [IW-1:0] b_feed  [COLS];
  logic signed [IW-1:0] a_sh_p1 [ROWS][COLS];
  logic signed [IW-1:0] b_sh_p1 [ROWS][COLS];
  logic signed [OW-1:0] acc_p1  [ROWS][COLS];
  logic signed [OW-1:0] acc_nxt [ROWS][COLS];

  function automatic logic signed [2*IW-1:0] mul_op(input logic signed [IW-1:0] a,
                                                    input logic signed [IW-1:0] b);
    return (2*IW)'(a) * (2*IW)'(b);
  endfunction

`ifdef SYSTOLIC_SATURATE_EN
  localparam logic signed [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

  logic ovf_any;
  logic sat_q;

  function automatic logic signed [OW-1:0] sat_mac(input logic signed [OW-1:0] acc,
                                                   input logic signed [IW-1:0] a,
                                                   input logic signed [IW-1:0] b);
    logic signed [OW:0] s;
    s = (OW+1)'(acc) + (OW+1)'(mul_op(a, b));
    if (s[OW] != s[OW-1]) return s[OW] ? SAT_MIN : SAT_MAX;
    return s[OW-1:0];
  endfunction

  function automatic logic mac_ovf(input logic signed [OW-1:0] acc,
                                   input logic signed [IW-1:0] a,
                                   input logic signed [IW-1:0] b);
    logic signed [OW:0] s;
    s = (OW+1)'(acc) + (OW+1)'(mul_op(a, b));
    return s[OW] != s[OW-1];
  endfunction
`else
  function automatic logic signed [OW-1:0] wrap_mac(input logic signed [OW-1:0] acc,
                                                    input logic signed [IW-1:0] a,
                                                    input logic signed [IW-1:0] b);
    return acc + OW'(mul_op(a, b));
  endfunction
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (t_p0 == T_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The edge registers are loaded one step ahead, so the feeders look at step t+1
  // (or step 0 straight from the ports on the accepting edge).
  assign step_nxt = start_acc ? 0 : int'(t_p0) + 1;

  // Skew feeders: element entering the left/top edge at the next step, zero bubbles otherwise
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_feed[i] = '0;
      for (int k = 0; k < DEPTH; k++)
        if (step_nxt == i + k)
          a_feed[i] = start_acc ? $signed(a_mat[i][k]) : a_cap_p0[i][k];
    end
    for (int j = 0; j < COLS; j++) begin
      b_feed[j] = '0;
      for (int k = 0; k < DEPTH; k++)
        if (step_nxt == j + k)
          b_feed[j] = start_acc ? $signed(b_mat[k][j]) : b_cap_p0[k][j];
    end
  end

  // PE multiply-accumulate for the current step
  always_comb begin
`ifdef SYSTOLIC_SATURATE_EN
    ovf_any = 1'b0;
`endif
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
`ifdef SYSTOLIC_SATURATE_EN
        acc_nxt[i][j] = sat_mac(acc_p1[i][j], a_sh_p1[i][j], b_sh_p1[i][j]);
        ovf_any       = ovf_any | mac_ovf(acc_p1[i][j], a_sh_p1[i][j], b_sh_p1[i][j]);
`else
        acc_nxt[i][j] = wrap_mac(acc_p1[i][j], a_sh_p1[i][j], b_sh_p1[i][j]);
`endif
      end
  end

  // Operand capture, step counter, skew shift registers and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      t_p0    <= '0;
      c_valid <= 1'b0;
      for (int i = 0; i < ROWS; i++)
        for (int k = 0; k < DEPTH; k++) a_cap_p0[i][k] <= '0;
      for (int k = 0; k < DEPTH; k++)
        for (int j = 0; j < COLS; j++) b_cap_p0[k][j] <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_sh_p1[i][j] <= '0;
          b_sh_p1[i][j] <= '0;
          acc_p1[i][j]  <= '0;
        end
    end else if (start_acc) begin
      // ---- p0: job capture
      t_p0    <= '0;
      c_valid <= 1'b0;
      for (int i = 0; i < ROWS; i++)
        for (int k = 0; k < DEPTH; k++) a_cap_p0[i][k] <= $signed(a_mat[i][k]);
      for (int k = 0; k < DEPTH; k++)
        for (int j = 0; j < COLS; j++) b_cap_p0[k][j] <= $signed(b_mat[k][j]);
      // ---- p1: array primed with step 0, accumulators cleared
      for (int i = 0; i < ROWS; i++) begin
        a_sh_p1[i][0] <= a_feed[i];
        for (int j = 1; j < COLS; j++) a_sh_p1[i][j] <= '0;
      end
      for (int j = 0; j < COLS; j++) begin
        b_sh_p1[0][j] <= b_feed[j];
        for (int i = 1; i < ROWS; i++) b_sh_p1[i][j] <= '0;
      end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc_p1[i][j] <= '0;
    end else if (busy) begin
      // ---- p0: step counter
      t_p0 <= t_p0 + 1'b1;
      if (t_p0 == T_LAST) c_valid <= 1'b1;
      // ---- p1: operands advance one PE right/down, every PE accumulates
      for (int i = 0; i < ROWS; i++) begin
        a_sh_p1[i][0] <= a_feed[i];
        for (int j = 1; j < COLS; j++) a_sh_p1[i][j] <= a_sh_p1[i][j-1];
      end
      for (int j = 0; j < COLS; j++) begin
        b_sh_p1[0][j] <= b_feed[j];
        for (int i = 1; i < ROWS; i++) b_sh_p1[i][j] <= b_sh_p1[i-1][j];
      end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc_p1[i][j] <= acc_nxt[i][j];
    end
  end

`ifdef SYSTOLIC_SATURATE_EN
  // Sticky per-job clamp indicator, held alongside the result
  always_ff @(posedge clk) begin
    if (rst || start_acc)  sat_q <= 1'b0;
    else if (busy && ovf_any) sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`endif

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      assign c_mat[i][j] = acc_p1[i][j];
    end
  end

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Directed testbench for systolic_gemm_engine: several array shapes, handshake
// timing, ignored restarts, mid-run reset, signed and overflow behaviour.
`timescale 1ns/1ps
module tb_systolic_gemm_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  // 2x2x2 instance
  logic                   start2, busy2, done2, cv2;
  logic [1:0][1:0][7:0]   a2, b2;
  logic [1:0][1:0][31:0]  c2;
  // 4x4x4 defaults
  logic                   start4, busy4, done4, cv4;
  logic [3:0][3:0][7:0]   a4, b4;
  logic [3:0][3:0][31:0]  c4;
  // 2x2, DEPTH 4, 16-bit accumulators
  logic                   start16, busy16, done16, cv16;
  logic [1:0][3:0][7:0]   a16;
  logic [3:0][1:0][7:0]   b16;
  logic [1:0][1:0][15:0]  c16;
  // 3x5, DEPTH 2
  logic                   start35, busy35, done35, cv35;
  logic [2:0][1:0][7:0]   a35;
  logic [1:0][4:0][7:0]   b35;
  logic [2:0][4:0][31:0]  c35;
  int                     ref35 [3][5];
  // 1x1x1
  logic                   start1, busy1, done1, cv1;
  logic [0:0][0:0][7:0]   a1, b1;
  logic [0:0][0:0][31:0]  c1;
`ifdef SYSTOLIC_SATURATE_EN
  logic [4:0]             sf;
`endif

  systolic_gemm_engine #(.ROWS(2), .COLS(2), .DEPTH(2), .INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(32)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a_mat(a2), .b_mat(b2),
    .busy(busy2), .done(done2), .c_valid(cv2), .c_mat(c2)
`ifdef SYSTOLIC_SATURATE_EN
    , .sat_flag(sf[0])
`endif
  );

  systolic_gemm_engine u4 (
    .clk(clk), .rst(rst), .start(start4), .a_mat(a4), .b_mat(b4),
    .busy(busy4), .done(done4), .c_valid(cv4), .c_mat(c4)
`ifdef SYSTOLIC_SATURATE_EN
    , .sat_flag(sf[1])
`endif
  );

  systolic_gemm_engine #(.ROWS(2), .COLS(2), .DEPTH(4), .INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a_mat(a16), .b_mat(b16),
    .busy(busy16), .done(done16), .c_valid(cv16), .c_mat(c16)
`ifdef SYSTOLIC_SATURATE_EN
    , .sat_flag(sf[2])
`endif
  );

  systolic_gemm_engine #(.ROWS(3), .COLS(5), .DEPTH(2), .INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(32)) u35 (
    .clk(clk), .rst(rst), .start(start35), .a_mat(a35), .b_mat(b35),
    .busy(busy35), .done(done35), .c_valid(cv35), .c_mat(c35)
`ifdef SYSTOLIC_SATURATE_EN
    , .sat_flag(sf[3])
`endif
  );

  systolic_gemm_engine #(.ROWS(1), .COLS(1), .DEPTH(1), .INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a_mat(a1), .b_mat(b1),
    .busy(busy1), .done(done1), .c_valid(cv1), .c_mat(c1)
`ifdef SYSTOLIC_SATURATE_EN
    , .sat_flag(sf[4])
`endif
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; observe 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int a00, input int a01, input int a10, input int a11,
                      input int b00, input int b01, input int b10, input int b11);
    a2[0][0] = 8'(a00); a2[0][1] = 8'(a01); a2[1][0] = 8'(a10); a2[1][1] = 8'(a11);
    b2[0][0] = 8'(b00); b2[0][1] = 8'(b01); b2[1][0] = 8'(b10); b2[1][1] = 8'(b11);
  endtask

  task automatic chk_c2(input string tag, input int e00, input int e01, input int e10, input int e11);
    chk({tag, "_c00"}, longint'($signed(c2[0][0])), longint'(e00));
    chk({tag, "_c01"}, longint'($signed(c2[0][1])), longint'(e01));
    chk({tag, "_c10"}, longint'($signed(c2[1][0])), longint'(e10));
    chk({tag, "_c11"}, longint'($signed(c2[1][1])), longint'(e11));
  endtask

  // Start a 2x2x2 job (T=4) in the current cycle; returns in its DONE cycle (cycle 5).
  task automatic run2(input string tag, input int e00, input int e01, input int e10, input int e11);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk({tag, "_busy"}, longint'(busy2), 1);
      chk({tag, "_done_early"}, longint'(done2), 0);
      chk({tag, "_cv_run"}, longint'(cv2), 0);
      step();
    end
    chk({tag, "_done"}, longint'(done2), 1);
    chk({tag, "_busy_end"}, longint'(busy2), 0);
    chk({tag, "_cv"}, longint'(cv2), 1);
    chk_c2(tag, e00, e01, e10, e11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start2 = 1'b0; start4 = 1'b0; start16 = 1'b0; start35 = 1'b0; start1 = 1'b0;
    a2 = '0; b2 = '0; a4 = '0; b4 = '0; a16 = '0; b16 = '0;
    a35 = '0; b35 = '0; a1 = '0; b1 = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", longint'(busy2), 0);
    chk("rst_done", longint'(done2), 0);
    chk("rst_cv", longint'(cv2), 0);
    chk_c2("rst", 0, 0, 0, 0);

    // Basic 2x2 product
    set2(1, 2, 3, 4, 5, 6, 7, 8);
    run2("mm2", 19, 22, 43, 50);
    step();
    chk("mm2_hold_done", longint'(done2), 0);
    chk("mm2_hold_cv", longint'(cv2), 1);
    chk_c2("mm2_hold", 19, 22, 43, 50);

    // Starts in RUN and DONE ignored; start in cycle T+2 accepted
    set2(2, 0, 0, 2, 1, -1, 3, 4);
    start2 = 1'b1;
    step();                                  // cycle 1
    start2 = 1'b0;
    step();                                  // cycle 2
    set2(9, 9, 9, 9, 9, 9, 9, 9);
    start2 = 1'b1;
    step();                                  // cycle 3
    start2 = 1'b0;
    chk("ign_busy", longint'(busy2), 1);
    step();
    step();                                  // cycle 5
    chk("ign_done", longint'(done2), 1);
    chk_c2("ign_first", 2, -2, 6, 8);
    start2 = 1'b1;
    step();                                  // cycle 6 (IDLE)
    chk("ign_idle_busy", longint'(busy2), 0);
    chk("ign_idle_done", longint'(done2), 0);
    chk("ign_idle_cv", longint'(cv2), 1);
    chk_c2("ign_keep", 2, -2, 6, 8);
    set2(1, 2, 3, 4, 5, 6, 7, 8);
    step();                                  // cycle 7
    start2 = 1'b0;
    chk("rs_cv_drop", longint'(cv2), 0);
    chk("rs_busy", longint'(busy2), 1);
    step();
    step();
    step();                                  // cycle 10
    chk("rs_done_early", longint'(done2), 0);
    step();                                  // cycle 11
    chk("rs_done", longint'(done2), 1);
    chk("rs_cv", longint'(cv2), 1);
    chk_c2("rs_second", 19, 22, 43, 50);
    step();

    // Reset in cycle 3 of a run, then a clean job
    set2(2, 0, 0, 2, 1, -1, 3, 4);
    start2 = 1'b1;
    step();                                  // cycle 1
    start2 = 1'b0;
    step();
    step();                                  // cycle 3
    rst = 1'b1;
    step();                                  // cycle 4
    rst = 1'b0;
    chk("mrst_busy", longint'(busy2), 0);
    chk("mrst_done", longint'(done2), 0);
    chk("mrst_cv", longint'(cv2), 0);
    chk_c2("mrst", 0, 0, 0, 0);
    step();
    chk("mrst_stay_idle", longint'(busy2), 0);
    set2(1, -2, 3, 4, 5, 6, -7, 8);
    run2("fresh", 19, -10, -13, 50);
    step();

    // Defaults: most negative operands
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a4[i][k] = 8'h80;
        b4[i][k] = 8'h80;
      end
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("neg_busy", longint'(busy4), 1);
      step();
    end
    chk("neg_done", longint'(done4), 1);
    chk("neg_cv", longint'(cv4), 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("neg_c", longint'($signed(c4[i][j])), 65536);
    step();

    // Defaults: negative A times identity returns A
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a4[i][k] = 8'(-(4 * i + k + 1));
        b4[i][k] = (i == k) ? 8'd1 : 8'd0;
      end
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 10; c++) step();
    chk("ident_done", longint'(done4), 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("ident_c", longint'($signed(c4[i][j])), longint'(-(4 * i + j + 1)));
    step();

    // 16-bit accumulator overflow, all operands 127
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        a16[i][k] = 8'd127;
        b16[k][i] = 8'd127;
      end
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    for (int c = 1; c <= 6; c++) step();
    chk("ovf_done", longint'(done16), 1);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
`ifdef SYSTOLIC_SATURATE_EN
        chk("ovf_c", longint'($signed(c16[i][j])), 32767);
    chk("ovf_sat_flag", longint'(sf[2]), 1);
    chk("ovf_other_flags", longint'(sf[1:0]), 0);
`else
        chk("ovf_c", longint'($signed(c16[i][j])), -1020);
`endif
    step();

    // Non-square 3x5, DEPTH 2, random operands against a reference product
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2; k++) a35[i][k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 5; j++) b35[k][j] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 5; j++) begin
        ref35[i][j] = 0;
        for (int k = 0; k < 2; k++)
          ref35[i][j] = ref35[i][j] + int'($signed(a35[i][k])) * int'($signed(b35[k][j]));
      end
    start35 = 1'b1;
    step();
    start35 = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    chk("ns_busy8", longint'(busy35), 1);
    chk("ns_done8", longint'(done35), 0);
    step();                                  // cycle 9
    chk("ns_done9", longint'(done35), 1);
    chk("ns_cv", longint'(cv35), 1);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 5; j++)
        chk("ns_c", longint'($signed(c35[i][j])), longint'(ref35[i][j]));
    step();

    // Smallest array: T=1, done in cycle 2
    a1[0][0] = 8'(-7);
    b1[0][0] = 8'd9;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("one_busy", longint'(busy1), 1);
    chk("one_done_early", longint'(done1), 0);
    step();
    chk("one_done", longint'(done1), 1);
    chk("one_cv", longint'(cv1), 1);
    chk("one_c", longint'($signed(c1[0][0])), -63);
`ifdef SYSTOLIC_SATURATE_EN
    chk("one_sat_flag", longint'(sf[4]), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
